// File: rtl/mem_bus_pkg.sv
// rtl/mem_bus_pkg.sv - shared types and constants for the two-port RAM arbiter
package mem_bus_pkg;

  localparam int DataW = 32;
  localparam int StrbW = 4;

  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } state_t;

  typedef logic port_id_t;

  localparam port_id_t PORT0 = 1'b0;
  localparam port_id_t PORT1 = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-requester round-robin selector, one-hot grant
module rr_arb2
  import mem_bus_pkg::*;
(
  input  logic [1:0] req,
  input  port_id_t   last,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    unique case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      // Contention: the port that did not win last time goes first.
      2'b11:   grant = (last == PORT1) ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - arbitrates CPU and UART-loader ports onto one
// synchronous RAM; one transaction in flight, grant in IDLE, ready in RESP.
module mem_bus_arbiter
  import mem_bus_pkg::*;
#(
  parameter int RamWords = 256,
  parameter int AddrW    = $clog2(RamWords)
) (
  input  logic             clk_i,
  input  logic             reset_ni,

  input  logic             m0_valid_i,
  input  logic [31:0]      m0_addr_i,
  input  logic [31:0]      m0_wdata_i,
  input  logic [3:0]       m0_wstrb_i,
  output logic             m0_ready_o,
  output logic [31:0]      m0_rdata_o,

  input  logic             m1_valid_i,
  input  logic [31:0]      m1_addr_i,
  input  logic [31:0]      m1_wdata_i,
  input  logic [3:0]       m1_wstrb_i,
  output logic             m1_ready_o,
  output logic [31:0]      m1_rdata_o,

  output logic             ram_en_o,
  output logic [3:0]       ram_wen_o,
  output logic [AddrW-1:0] ram_addr_o,
  output logic [31:0]      ram_wdata_o,
  input  logic [31:0]      ram_rdata_i,

  output logic             busy_o,
  output logic             oob_err_o
);

  localparam logic [31:0] OobBase = 32'(4 * RamWords);

  state_t     state_q, state_d;
  port_id_t   grant_q, grant_d;
  port_id_t   last_q, last_d;
  logic       oob_q, oob_d;
  logic       oob_err_q, oob_err_d;

  logic [1:0]       req;
  logic [1:0]       rr_grant;
  port_id_t         win;
  logic             take;
  logic [31:0]      sel_addr;
  logic [31:0]      sel_wdata;
  logic [StrbW-1:0] sel_wstrb;
  logic             sel_oob;
  logic             resp;

  assign req = {m1_valid_i, m0_valid_i};

  rr_arb2 u_rr_arb2 (
    .req   (req),
    .last  (last_q),
    .grant (rr_grant)
  );

  assign win       = rr_grant[1] ? PORT1 : PORT0;
  assign sel_addr  = (win == PORT1) ? m1_addr_i  : m0_addr_i;
  assign sel_wdata = (win == PORT1) ? m1_wdata_i : m0_wdata_i;
  assign sel_wstrb = (win == PORT1) ? m1_wstrb_i : m0_wstrb_i;
  assign sel_oob   = (sel_addr >= OobBase);

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    last_d    = last_q;
    oob_d     = oob_q;
    oob_err_d = oob_err_q;
    take      = 1'b0;
    unique case (state_q)
      IDLE: begin
        // reset_ni gating keeps the RAM strobe quiet while reset is held.
        if (reset_ni && (req != 2'b00)) begin
          take    = 1'b1;
          state_d = RESP;
          grant_d = win;
          last_d  = win;
          oob_d   = sel_oob;
          if (sel_oob) begin
            oob_err_d = 1'b1;
          end
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q   <= IDLE;
      grant_q   <= PORT0;
      last_q    <= PORT1;
      oob_q     <= 1'b0;
      oob_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      last_q    <= last_d;
      oob_q     <= oob_d;
      oob_err_q <= oob_err_d;
    end
  end

  assign ram_en_o    = take && !sel_oob;
  assign ram_wen_o   = ram_en_o ? sel_wstrb : '0;
  assign ram_addr_o  = ram_en_o ? sel_addr[AddrW+1:2] : '0;
  assign ram_wdata_o = ram_en_o ? sel_wdata : '0;

  assign resp       = (state_q == RESP);
  assign busy_o     = resp;
  assign oob_err_o  = oob_err_q;
  assign m0_ready_o = resp && (grant_q == PORT0);
  assign m1_ready_o = resp && (grant_q == PORT1);
  assign m0_rdata_o = (m0_ready_o && !oob_q) ? ram_rdata_i : '0;
  assign m1_rdata_o = (m1_ready_o && !oob_q) ? ram_rdata_i : '0;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb/tb_mem_bus_arbiter.sv - directed self-checking bench for mem_bus_arbiter
module tb_mem_bus_arbiter;

  logic        clk_i = 1'b0;
  logic        reset_ni;
  logic        m0_valid_i, m1_valid_i;
  logic [31:0] m0_addr_i, m1_addr_i, m0_wdata_i, m1_wdata_i;
  logic [3:0]  m0_wstrb_i, m1_wstrb_i;
  logic        m0_ready_o, m1_ready_o;
  logic [31:0] m0_rdata_o, m1_rdata_o;
  logic        ram_en_o;
  logic [3:0]  ram_wen_o;
  logic [7:0]  ram_addr_o;
  logic [31:0] ram_wdata_o;
  logic [31:0] ram_rdata_i;
  logic        busy_o, oob_err_o;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] mem [256];

  always #5 clk_i = ~clk_i;

  mem_bus_arbiter #(.RamWords(256)) dut (
    .clk_i(clk_i), .reset_ni(reset_ni),
    .m0_valid_i(m0_valid_i), .m0_addr_i(m0_addr_i), .m0_wdata_i(m0_wdata_i),
    .m0_wstrb_i(m0_wstrb_i), .m0_ready_o(m0_ready_o), .m0_rdata_o(m0_rdata_o),
    .m1_valid_i(m1_valid_i), .m1_addr_i(m1_addr_i), .m1_wdata_i(m1_wdata_i),
    .m1_wstrb_i(m1_wstrb_i), .m1_ready_o(m1_ready_o), .m1_rdata_o(m1_rdata_o),
    .ram_en_o(ram_en_o), .ram_wen_o(ram_wen_o), .ram_addr_o(ram_addr_o),
    .ram_wdata_o(ram_wdata_o), .ram_rdata_i(ram_rdata_i),
    .busy_o(busy_o), .oob_err_o(oob_err_o)
  );

  // External synchronous RAM: byte-enabled write, old-data read.
  always @(posedge clk_i) begin
    if (ram_en_o) begin
      ram_rdata_i <= mem[ram_addr_o];
      for (int b = 0; b < 4; b++) begin
        if (ram_wen_o[b]) mem[ram_addr_o][b*8 +: 8] <= ram_wdata_o[b*8 +: 8];
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at negedge+1 in IDLE; issues one request and checks grant, ready, return to IDLE.
  task automatic txn(input int port, input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [3:0] wstrb, input logic exp_en, input logic [31:0] exp_word,
                     input logic chk_rd, input logic [31:0] exp_rd);
    if (port == 0) begin
      m0_valid_i = 1'b1; m0_addr_i = addr; m0_wdata_i = wdata; m0_wstrb_i = wstrb;
    end else begin
      m1_valid_i = 1'b1; m1_addr_i = addr; m1_wdata_i = wdata; m1_wstrb_i = wstrb;
    end
    #1;
    chk("grant_en", {31'd0, ram_en_o}, {31'd0, exp_en});
    chk("grant_wen", {28'd0, ram_wen_o}, exp_en ? {28'd0, wstrb} : 32'd0);
    if (exp_en) chk("grant_addr", {24'd0, ram_addr_o}, exp_word);
    @(negedge clk_i); #1;
    m0_valid_i = 1'b0; m1_valid_i = 1'b0;
    chk("resp_busy", {31'd0, busy_o}, 32'd1);
    chk("resp_m0_ready", {31'd0, m0_ready_o}, (port == 0) ? 32'd1 : 32'd0);
    chk("resp_m1_ready", {31'd0, m1_ready_o}, (port == 1) ? 32'd1 : 32'd0);
    chk("resp_ram_en", {31'd0, ram_en_o}, 32'd0);
    if (chk_rd) chk("resp_rdata", (port == 0) ? m0_rdata_o : m1_rdata_o, exp_rd);
    @(negedge clk_i); #1;
    chk("idle_busy", {31'd0, busy_o}, 32'd0);
    chk("idle_ready", {30'd0, m1_ready_o, m0_ready_o}, 32'd0);
  endtask

  logic [31:0] cont_word [4];
  int          cont_port [4];

  initial begin
    reset_ni   = 1'b0;
    m0_valid_i = 1'b0; m0_addr_i = '0; m0_wdata_i = '0; m0_wstrb_i = '0;
    m1_valid_i = 1'b0; m1_addr_i = '0; m1_wdata_i = '0; m1_wstrb_i = '0;
    @(negedge clk_i); @(negedge clk_i); #1;
    chk("rst_busy", {31'd0, busy_o}, 32'd0);
    chk("rst_ready", {30'd0, m1_ready_o, m0_ready_o}, 32'd0);
    chk("rst_ram_en", {27'd0, ram_wen_o, ram_en_o}, 32'd0);
    chk("rst_oob", {31'd0, oob_err_o}, 32'd0);
    reset_ni = 1'b1;

    // Contention right after reset: 0,1,0,1
    cont_word[0] = 32'd8;  cont_word[1] = 32'd17; cont_word[2] = 32'd8;  cont_word[3] = 32'd17;
    cont_port[0] = 0;      cont_port[1] = 1;      cont_port[2] = 0;      cont_port[3] = 1;
    m0_addr_i = 32'h20; m0_wstrb_i = 4'h0; m0_valid_i = 1'b1;
    m1_addr_i = 32'h44; m1_wstrb_i = 4'h0; m1_valid_i = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      chk("cont_en", {31'd0, ram_en_o}, 32'd1);
      chk("cont_addr", {24'd0, ram_addr_o}, cont_word[i]);
      @(negedge clk_i); #1;
      chk("cont_m0_ready", {31'd0, m0_ready_o}, (cont_port[i] == 0) ? 32'd1 : 32'd0);
      chk("cont_m1_ready", {31'd0, m1_ready_o}, (cont_port[i] == 1) ? 32'd1 : 32'd0);
      @(negedge clk_i); #1;
    end
    m0_valid_i = 1'b0; m1_valid_i = 1'b0;
    @(negedge clk_i); #1;

    // Port 0 write/read, plus unaligned read of the same word
    txn(0, 32'h10, 32'hDEADBEEF, 4'hF, 1'b1, 32'd4, 1'b0, 32'd0);
    txn(0, 32'h10, 32'h0, 4'h0, 1'b1, 32'd4, 1'b1, 32'hDEADBEEF);
    txn(0, 32'h13, 32'h0, 4'h0, 1'b1, 32'd4, 1'b1, 32'hDEADBEEF);

    // Port 1 byte-merge
    txn(1, 32'h80, 32'hAABBCCDD, 4'hF, 1'b1, 32'd32, 1'b0, 32'd0);
    txn(1, 32'h80, 32'h00000011, 4'h1, 1'b1, 32'd32, 1'b1, 32'hAABBCCDD);
    txn(1, 32'h80, 32'h0, 4'h0, 1'b1, 32'd32, 1'b1, 32'hAABBCC11);

    // Out of range: last legal word, then just past the end
    chk("pre_oob", {31'd0, oob_err_o}, 32'd0);
    txn(0, 32'h3FC, 32'h0, 4'h0, 1'b1, 32'd255, 1'b0, 32'd0);
    chk("edge_no_oob", {31'd0, oob_err_o}, 32'd0);
    txn(0, 32'h400, 32'h0, 4'h0, 1'b0, 32'd0, 1'b1, 32'd0);
    chk("oob_set", {31'd0, oob_err_o}, 32'd1);
    txn(0, 32'h404, 32'h12345678, 4'hF, 1'b0, 32'd0, 1'b1, 32'd0);
    txn(1, 32'h10, 32'h0, 4'h0, 1'b1, 32'd4, 1'b1, 32'hDEADBEEF);
    chk("oob_sticky", {31'd0, oob_err_o}, 32'd1);

    // Port 1 drops valid after grant; port 0 follows
    m1_addr_i = 32'h80; m1_wstrb_i = 4'h0; m1_valid_i = 1'b1;
    #1;
    chk("drop_grant_addr", {24'd0, ram_addr_o}, 32'd32);
    @(negedge clk_i); #1;
    m1_valid_i = 1'b0;
    m0_addr_i = 32'h10; m0_wstrb_i = 4'h0; m0_valid_i = 1'b1;
    #1;
    chk("drop_m1_ready", {31'd0, m1_ready_o}, 32'd1);
    chk("drop_m1_rdata", m1_rdata_o, 32'hAABBCC11);
    chk("drop_m0_ready", {31'd0, m0_ready_o}, 32'd0);
    chk("drop_m0_rdata", m0_rdata_o, 32'd0);
    @(negedge clk_i); #1;
    chk("drop_m1_once", {31'd0, m1_ready_o}, 32'd0);
    chk("drop_m0_grant", {31'd0, ram_en_o}, 32'd1);
    chk("drop_m0_addr", {24'd0, ram_addr_o}, 32'd4);
    @(negedge clk_i); #1;
    m0_valid_i = 1'b0;
    chk("drop_m0_ready2", {31'd0, m0_ready_o}, 32'd1);
    chk("drop_m0_rdata2", m0_rdata_o, 32'hDEADBEEF);
    @(negedge clk_i); #1;

    // Reset in RESP aborts; the still-pending request is served afterwards
    m0_addr_i = 32'h10; m0_wstrb_i = 4'h0; m0_valid_i = 1'b1;
    @(negedge clk_i); #1;
    chk("rr_busy_pre", {31'd0, busy_o}, 32'd1);
    reset_ni = 1'b0;
    #1;
    chk("rr_ready", {30'd0, m1_ready_o, m0_ready_o}, 32'd0);
    chk("rr_busy", {31'd0, busy_o}, 32'd0);
    chk("rr_ram", {27'd0, ram_wen_o, ram_en_o}, 32'd0);
    chk("rr_oob", {31'd0, oob_err_o}, 32'd0);
    @(negedge clk_i); #1;
    chk("rr_hold_ready", {31'd0, m0_ready_o}, 32'd0);
    reset_ni = 1'b1;
    #1;
    chk("rr_regrant", {31'd0, ram_en_o}, 32'd1);
    chk("rr_regrant_addr", {24'd0, ram_addr_o}, 32'd4);
    @(negedge clk_i); #1;
    m0_valid_i = 1'b0;
    chk("rr_served", {31'd0, m0_ready_o}, 32'd1);
    chk("rr_served_rdata", m0_rdata_o, 32'hDEADBEEF);
    @(negedge clk_i); #1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mem_bus_arbiter.md
MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

Interface
REQ-001 The block SHALL have parameter RamWords, default 256, meaning the number of 32-bit words in the shared RAM.
REQ-002 The block SHALL have parameter AddrW, default $clog2(RamWords), meaning the RAM word-address width.
REQ-003 Ports (name dir width meaning) SHALL be:
- clk_i  in  1  single clock; all logic on its rising edge.
- reset_ni  in  1  asynchronous, active-low reset.
- m0_valid_i  in  1  port 0 (CPU) request valid.
- m0_addr_i  in  32  port 0 byte address.
- m0_wdata_i  in  32  port 0 write data.
- m0_wstrb_i  in  4  port 0 byte write strobes; 0 means read.
- m0_ready_o  out  1  port 0 one-cycle completion pulse.
- m0_rdata_o  out  32  port 0 read data, valid with m0_ready_o.
- m1_valid_i, m1_addr_i, m1_wdata_i, m1_wstrb_i, m1_ready_o, m1_rdata_o: same as port 0, for port 1 (UART loader).
- ram_en_o  out  1  RAM access strobe.
- ram_wen_o  out  4  RAM byte write enables.
- ram_addr_o  out  AddrW  RAM word address.
- ram_wdata_o  out  32  RAM write data.
- ram_rdata_i  in  32  RAM read data, one cycle after ram_en_o.
- busy_o  out  1  high while a transaction is in RESP.
- oob_err_o  out  1  sticky out-of-range access flag.

Function
REQ-004 The FSM SHALL have two states, IDLE and RESP; at most one transaction SHALL be in flight.
REQ-005 In IDLE, with any valid high, the block SHALL grant one port combinationally that cycle and move to RESP at the next edge.
- Grant cycle: drive ram_en_o=1, ram_addr_o=addr[AddrW+1:2], ram_wdata_o, ram_wen_o=wstrb.
- Grant register: store the winning port.
REQ-006 Arbitration SHALL be round-robin.
- Only one valid high: that port wins.
- Both valid high: the port not granted last wins.
- The last-grant pointer SHALL update only on a grant.
REQ-007 In RESP, the granted port's ready_o SHALL be 1 for exactly one cycle; the state SHALL then return to IDLE; no RAM access SHALL be issued in RESP.
- Consequence: latency grant-to-ready is 1 cycle; peak throughput is one access per 2 cycles.
REQ-008 During the ready cycle, the granted port's rdata_o SHALL equal ram_rdata_i; otherwise both rdata_o SHALL be 0.
REQ-009 The non-granted port's ready_o SHALL stay 0; its request SHALL remain pending and be served no later than the next IDLE grant.
REQ-010 An address >= 4*RamWords is out-of-bounds (OOB).
- ram_en_o and ram_wen_o SHALL stay 0.
- ready SHALL still pulse in RESP, with rdata_o=0.
- oob_err_o SHALL be set and hold until reset.
REQ-011 ram_addr_o SHALL ignore address bits [1:0]; unaligned addresses SHALL be word-truncated without error.
REQ-012 If a requester drops valid after grant, the transaction SHALL still complete and the ready pulse SHALL still be issued.
REQ-013 busy_o SHALL equal (state==RESP).

Reset
REQ-014 On reset_ni low, the block SHALL asynchronously force:
- state=IDLE, ready_o=0, ram_en_o=0, ram_wen_o=0, busy_o=0, oob_err_o=0.
- last-grant=port 1, so port 0 wins first contention.
REQ-015 Reset asserted in RESP SHALL abort the transaction with no ready pulse; a write already issued in the grant cycle is not rolled back.
REQ-016 After reset deasserts, the first grant SHALL occur in the first IDLE cycle with a valid request.

Structure
REQ-017 Package mem_bus_pkg SHALL hold the state enum (IDLE, RESP), port-id type, and constants: data width 32, strobe width 4.
REQ-018 Round-robin selection SHALL be a sub-module rr_arb2 (req[1:0], last, grant[1:0]); the RAM itself stays external (ram_1r1w_sync).

Verification
REQ-019 The bench SHALL cover these directed scenarios:
- Port 0 writes 0xDEADBEEF to 0x10 with wstrb 0xF, then reads 0x10 -> m0_ready_o pulses 1 cycle after each grant; read m0_rdata_o=0xDEADBEEF.
- Both ports valid in the same cycle after reset -> port 0 granted first, port 1 next IDLE; further contention alternates 0,1,0,1.
- Port 1 writes 0xAABBCCDD, then writes 0x11 with wstrb 0x1, then reads -> 0xAABBCC11.
- Port 0 reads 0x400 with RamWords=256 -> ram_en_o stays 0, m0_ready_o pulses, rdata=0, oob_err_o=1 and stays set.
- reset_ni pulsed low during RESP -> no ready pulse, all outputs 0 immediately, next request served normally.
- Port 1 drops valid the cycle after grant -> m1_ready_o still pulses once; port 0 is not blocked.
